argmax_head: RTL and testbench

Classifier output stage of the CNN digit recogniser. It accepts the ten signed class scores from the final fully-connected layer as a valid/ready stream, one score per beat, and tracks the running maximum. At frame end it presents the winning class index on `numbers[3:0]` under a valid/ready handshake. It sits directly upstream of the top-level `numbers` output of `main`.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/argmax_cmp.sv | 24 ++
 rtl/argmax_head.sv | 121 ++++++++++++
 tb/tb_argmax_head.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Constants and types shared between the fully-connected layer and the classifier head.
package cnn_pkg;

    localparam int unsigned SCORE_W     = 16;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Running-maximum step: folds one indexed score into the current best (strict signed >, ties keep lower index).
module argmax_cmp #(
    parameter int unsigned W  = cnn_pkg::SCORE_W,
    parameter int unsigned IW = cnn_pkg::IDX_W
) (
    input  logic signed [W-1:0]  score,
    input  logic signed [W-1:0]  best,
    input  logic        [IW-1:0] idx,
    input  logic        [IW-1:0] best_idx,
    output logic signed [W-1:0]  best_nxt,
    output logic        [IW-1:0] best_idx_nxt
);

    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
        // The first beat of a frame always seeds the maximum.
        if (idx == '0 || score > best) begin
            best_nxt     = score;
            best_idx_nxt = idx;
        end
    end

endmodule

// File: rtl/argmax_head.sv
// Classifier output stage: streams class scores, tracks the argmax and hands the winning index downstream.
module argmax_head #(
    parameter int unsigned SCORE_W     = cnn_pkg::SCORE_W,
    parameter int unsigned NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [SCORE_W-1:0] s_score,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [3:0]                numbers,
    output logic                      frame_err,
    output logic [CNT_W-1:0]          frame_cnt
);

    import cnn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_t              state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [SCORE_W-1:0]  best_q, best_d;
    logic [IDX_W-1:0]           best_idx_q, best_idx_d;
    logic [3:0]                 numbers_d;
    logic                       err_d;
    logic [CNT_W-1:0]           cnt_d;

    logic signed [SCORE_W-1:0]  cmp_best;
    logic [IDX_W-1:0]           cmp_idx;
    logic                       accept_c;

    argmax_cmp #(
        .W  (SCORE_W),
        .IW (IDX_W)
    ) u_cmp (
        .score        (s_score),
        .best         (best_q),
        .idx          (idx_q),
        .best_idx     (best_idx_q),
        .best_nxt     (cmp_best),
        .best_idx_nxt (cmp_idx)
    );

    assign accept_c = s_valid && s_ready;

    // Next-state and datapath decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        numbers_d  = numbers;
        err_d      = 1'b0;
        cnt_d      = frame_cnt;
        unique case (state_q)
            ACCUM: begin
                if (accept_c) begin
                    if (s_last && idx_q == LAST_IDX) begin
                        numbers_d = 4'(cmp_idx);
                        idx_d     = '0;
                        state_d   = HOLD;
                    end else if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else if (idx_q == LAST_IDX) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        best_d     = cmp_best;
                        best_idx_d = cmp_idx;
                        idx_d      = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept_c && s_last) begin
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    cnt_d   = frame_cnt + CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // All state and outputs registered; handshake flags follow the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACCUM;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            numbers    <= '0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            numbers    <= numbers_d;
            frame_err  <= err_d;
            frame_cnt  <= cnt_d;
            s_ready    <= (state_d != HOLD);
            m_valid    <= (state_d == HOLD);
        end
    end

endmodule

// File: tb/tb_argmax_head.sv
// Scoreboard bench for argmax_head: directed frames push expected winners, a monitor checks each handshake.
module tb_argmax_head;

    typedef int vec_t [16];

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_score;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic [3:0]         numbers;
    logic               frame_err;
    logic [15:0]        frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q [$];
    int exp_cnt = 0;
    int err_seen = 0;
    int err_exp = 0;

    argmax_head #(
        .SCORE_W     (16),
        .NUM_CLASSES (10),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_score   (s_score),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .numbers   (numbers),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and tallies error pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) err_seen++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("numbers", int'(numbers), exp_q.pop_front());
                    check("frame_cnt_at_handshake", int'(frame_cnt), exp_cnt);
                    exp_cnt = (exp_cnt + 1) % 65536;
                end
            end
        end
    end

    // Drive n beats; s_last on beat last_at (-1 for none). A beat is taken when s_ready is high at the edge.
    task automatic send(input vec_t v, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_score = 16'(v[i]);
            s_last  = (i == last_at);
            while (!s_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("s_ready_timeout", 0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("result_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_numbers"}, int'(numbers), 0);
        check({tag, "_m_valid"}, int'(m_valid), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
        check({tag, "_s_ready"}, int'(s_ready), 0);
    endtask

    initial begin
        vec_t v;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_score = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Frame 1: tie between class 2 and 5 resolves to 2.
        v = '{3, -7, 12, 0, 5, 12, 1, -2, 9, 4, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(2);
        send(v, 10, 9);
        wait_idle();
        check("cnt_after_f1", int'(frame_cnt), 1);

        // Frame 2: all negative ascending, downstream stalls for 5 cycles.
        m_ready = 1'b0;
        v = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(9);
        send(v, 10, 9);
        for (int c = 0; c < 5; c++) begin
            check("stall_m_valid", int'(m_valid), 1);
            check("stall_s_ready", int'(s_ready), 0);
            check("stall_numbers", int'(numbers), 9);
            if (c < 4) @(negedge clk);
        end
        m_ready = 1'b1;
        wait_idle();
        check("cnt_after_f2", int'(frame_cnt), 2);

        // Short frame then a good frame whose max is class 0.
        v = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        err_exp++;
        send(v, 7, 6);
        repeat (3) @(negedge clk);
        check("short_err_count", err_seen, err_exp);
        check("short_no_result", int'(m_valid), 0);
        v = '{50, 1, 2, 3, 4, 5, 6, 7, 8, 50, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(0);
        send(v, 10, 9);
        wait_idle();
        check("cnt_after_short", int'(frame_cnt), 3);

        // Long frame of 13 beats, drained, then a good frame.
        v = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 100, 200, 300, 0, 0, 0};
        err_exp++;
        send(v, 13, 12);
        repeat (3) @(negedge clk);
        check("long_err_count", err_seen, err_exp);
        v = '{-5, -4, -3, -2, 40, 1, 2, 3, 39, 0, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(4);
        send(v, 10, 9);
        wait_idle();
        check("err_total", err_seen, err_exp);

        // Reset mid-frame after 4 beats, then a full frame with max at class 7.
        v = '{1, 2, 3, 99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send(v, 4, -1);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        v = '{1, 2, 3, 4, 5, 6, 7, 80, 8, 9, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(7);
        send(v, 10, 9);
        wait_idle();
        check("numbers_after_rst", int'(numbers), 7);
        check("cnt_after_rst", int'(frame_cnt), 1);

        // Signed extremes: first 0x7FFF wins over the later equal one.
        v = '{-32768, -32768, -32768, 32767, -1, 0, 100, -32768, 32767, 5, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(3);
        send(v, 10, 9);
        wait_idle();
        check("numbers_retained", int'(numbers), 3);
        check("cnt_final", int'(frame_cnt), 2);
        check("err_final", err_seen, err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
